// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state type and bus constants for the I2C register target
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK
    } i2c_tgt_state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;
    localparam int   RW_BIT   = 0;

endpackage

// File: rtl/i2c_line_sync.sv
// rtl/i2c_line_sync.sv - 2-FF line synchroniser with optional stable-value filter (I2C_TGT_GLITCH_FILTER_EN) and edge pulses
module i2c_line_sync #(
    parameter int FILT_LEN = 4
) (
    input  logic sys_clk,
    input  logic rstn,
    input  logic line_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0] sync_q;
    logic       line_s;
    logic       level_d;

    // Idle I2C lines are high, so reset to 1 to avoid a phantom edge.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], line_in};
    end

`ifdef I2C_TGT_GLITCH_FILTER_EN
    localparam int CNT_W = $clog2(FILT_LEN + 1);
    logic [CNT_W-1:0] stable_cnt;
    logic             filt_q;

    // Output follows the input only after FILT_LEN consecutive differing samples.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            filt_q     <= 1'b1;
            stable_cnt <= '0;
        end else if (sync_q[1] == filt_q) begin
            stable_cnt <= '0;
        end else if (stable_cnt == CNT_W'(FILT_LEN - 1)) begin
            filt_q     <= sync_q[1];
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt + 1'b1;
        end
    end
    assign line_s = filt_q;
`else
    logic filt_len_unused;
    assign filt_len_unused = (FILT_LEN > 0);
    assign line_s = sync_q[1];
`endif

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) level_d <= 1'b1;
        else       level_d <= line_s;
    end

    assign level = line_s;
    assign rise  = line_s & ~level_d;
    assign fall  = ~line_s & level_d;

endmodule

// File: rtl/i2c_target_regs.sv
// rtl/i2c_target_regs.sv - I2C target exposing a register file over a strobe bus; glitch filter via I2C_TGT_GLITCH_FILTER_EN
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h68,
    parameter int         NUM_REGS   = 64,
    parameter int         FILT_LEN   = 4
) (
    input  logic       sys_clk,
    input  logic       rstn,
    input  logic       i2c_scl,
    input  logic       i2c_sda_in,
    output logic       i2c_sda_oe,
    output logic       reg_write,
    output logic       reg_read,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    localparam int PTR_W = $clog2(NUM_REGS);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_sync #(.FILT_LEN(FILT_LEN)) u_scl_sync (
        .sys_clk(sys_clk), .rstn(rstn), .line_in(i2c_scl),
        .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_line_sync #(.FILT_LEN(FILT_LEN)) u_sda_sync (
        .sys_clk(sys_clk), .rstn(rstn), .line_in(i2c_sda_in),
        .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
    );

    logic start_det, stop_det;
    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;

    i2c_tgt_state_t   state, state_nxt;
    logic [7:0]       shreg, shreg_nxt;
    logic [3:0]       bit_cnt, bit_cnt_nxt;
    logic [PTR_W-1:0] ptr, ptr_nxt;
    logic             oe_nxt, busy_nxt, mack, mack_nxt, load_pend;
    logic             reg_write_nxt, reg_read_nxt;
    logic [7:0]       reg_addr_nxt, reg_wdata_nxt, byte_in;

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            ptr        <= '0;
            i2c_sda_oe <= 1'b0;
            busy       <= 1'b0;
            mack       <= 1'b0;
            load_pend  <= 1'b0;
            reg_write  <= 1'b0;
            reg_read   <= 1'b0;
            reg_addr   <= '0;
            reg_wdata  <= '0;
        end else begin
            state      <= state_nxt;
            shreg      <= shreg_nxt;
            bit_cnt    <= bit_cnt_nxt;
            ptr        <= ptr_nxt;
            i2c_sda_oe <= oe_nxt;
            busy       <= busy_nxt;
            mack       <= mack_nxt;
            load_pend  <= reg_read;
            reg_write  <= reg_write_nxt;
            reg_read   <= reg_read_nxt;
            reg_addr   <= reg_addr_nxt;
            reg_wdata  <= reg_wdata_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        shreg_nxt     = shreg;
        bit_cnt_nxt   = bit_cnt;
        ptr_nxt       = ptr;
        oe_nxt        = i2c_sda_oe;
        busy_nxt      = busy;
        mack_nxt      = mack;
        reg_write_nxt = 1'b0;
        reg_read_nxt  = 1'b0;
        reg_addr_nxt  = reg_addr;
        reg_wdata_nxt = reg_wdata;
        byte_in       = {shreg[6:0], sda_lvl};

        if (start_det) begin
            state_nxt   = ST_ADDR;
            bit_cnt_nxt = '0;
            oe_nxt      = 1'b0;
        end else if (stop_det) begin
            state_nxt = ST_IDLE;
            oe_nxt    = 1'b0;
            busy_nxt  = 1'b0;
        end else if (load_pend) begin
            // Read data arrives the cycle after the request; present its MSB at once.
            shreg_nxt   = reg_rdata;
            oe_nxt      = ~reg_rdata[7];
            bit_cnt_nxt = '0;
        end else if (scl_rise) begin
            case (state)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    shreg_nxt   = byte_in;
                    bit_cnt_nxt = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7 && state == ST_PTR) ptr_nxt = byte_in[PTR_W-1:0];
                    if (bit_cnt == 4'd7 && state == ST_WDATA) begin
                        reg_write_nxt = 1'b1;
                        reg_addr_nxt  = 8'(ptr);
                        reg_wdata_nxt = byte_in;
                        ptr_nxt       = ptr + 1'b1;
                    end
                end
                ST_RDATA:     bit_cnt_nxt = bit_cnt + 4'd1;
                ST_RDATA_ACK: mack_nxt = (sda_lvl == I2C_ACK);
                default: ;
            endcase
        end else if (scl_fall) begin
            case (state)
                ST_ADDR: if (bit_cnt == 4'd8) begin
                    if (shreg[7:1] == SLAVE_ADDR) begin
                        state_nxt = ST_ADDR_ACK;
                        oe_nxt    = 1'b1;
                        busy_nxt  = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                        oe_nxt    = 1'b0;
                        busy_nxt  = 1'b0;
                    end
                end
                ST_ADDR_ACK: begin
                    oe_nxt      = 1'b0;
                    bit_cnt_nxt = '0;
                    if (shreg[RW_BIT]) begin
                        state_nxt    = ST_RDATA;
                        reg_read_nxt = 1'b1;
                        reg_addr_nxt = 8'(ptr);
                        ptr_nxt      = ptr + 1'b1;
                    end else begin
                        state_nxt = ST_PTR;
                    end
                end
                ST_PTR: if (bit_cnt == 4'd8) begin
                    state_nxt = ST_PTR_ACK;
                    oe_nxt    = 1'b1;
                end
                ST_PTR_ACK, ST_WDATA_ACK: begin
                    state_nxt   = ST_WDATA;
                    oe_nxt      = 1'b0;
                    bit_cnt_nxt = '0;
                end
                ST_WDATA: if (bit_cnt == 4'd8) begin
                    state_nxt = ST_WDATA_ACK;
                    oe_nxt    = 1'b1;
                end
                ST_RDATA: begin
                    if (bit_cnt == 4'd8) begin
                        state_nxt = ST_RDATA_ACK;
                        oe_nxt    = 1'b0;
                    end else begin
                        shreg_nxt = {shreg[6:0], 1'b0};
                        oe_nxt    = ~shreg[6];
                    end
                end
                ST_RDATA_ACK: begin
                    bit_cnt_nxt = '0;
                    if (mack) begin
                        state_nxt    = ST_RDATA;
                        reg_read_nxt = 1'b1;
                        reg_addr_nxt = 8'(ptr);
                        ptr_nxt      = ptr + 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                        oe_nxt    = 1'b0;
                        busy_nxt  = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
// tb/tb_i2c_target_regs.sv - directed I2C master bench with register model for i2c_target_regs
module tb_i2c_target_regs;

    logic       sys_clk = 1'b0;
    logic       rstn = 1'b0;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       i2c_sda_oe, reg_write, reg_read, busy;
    logic [7:0] reg_addr, reg_wdata;
    logic [7:0] reg_rdata = 8'h00;

    logic [7:0] mem [0:63];
    logic [7:0] wr_addr [0:15];
    logic [7:0] wr_data [0:15];
    logic [7:0] rd_addr [0:15];
    int         wr_cnt = 0, rd_cnt = 0;
    logic       oe_seen = 1'b0, busy_seen = 1'b0;
    int         n_checks = 0, n_pass = 0;
    logic       ack;
    logic [7:0] rbyte;

    assign sda_line = sda_m & ~i2c_sda_oe;

    always #5 sys_clk = ~sys_clk;

    i2c_target_regs dut (
        .sys_clk(sys_clk), .rstn(rstn), .i2c_scl(scl),
        .i2c_sda_in(sda_line), .i2c_sda_oe(i2c_sda_oe),
        .reg_write(reg_write), .reg_read(reg_read),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata), .busy(busy)
    );

    always @(posedge sys_clk) begin
        if (reg_read) reg_rdata <= mem[reg_addr[5:0]];
        if (reg_read && rd_cnt < 16) begin
            rd_addr[rd_cnt] = reg_addr;
            rd_cnt = rd_cnt + 1;
        end
        if (reg_write && wr_cnt < 16) begin
            wr_addr[wr_cnt] = reg_addr;
            wr_data[wr_cnt] = reg_wdata;
            wr_cnt = wr_cnt + 1;
        end
        if (i2c_sda_oe) oe_seen = 1'b1;
        if (busy) busy_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_q();
        repeat (10) @(negedge sys_clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; scl = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl = 1'b0; wait_q();
    endtask

    task automatic i2c_rstart();
        sda_m = 1'b1; wait_q();
        scl = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_q();
        scl = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; wait_q();
        scl = 1'b1; wait_q(); wait_q();
        scl = 1'b0; wait_q();
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; wait_q();
        scl = 1'b1; wait_q();
        b = sda_line; wait_q();
        scl = 1'b0; wait_q();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic a);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(a);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic give_ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(give_ack ? 1'b0 : 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'(i);
        mem[7]    = 8'h77;
        mem[6'h3F] = 8'h11;
        mem[0]    = 8'h22;
        repeat (4) @(negedge sys_clk);
        check("rst_oe", {31'd0, i2c_sda_oe}, 32'd0);
        check("rst_write", {31'd0, reg_write}, 32'd0);
        check("rst_read", {31'd0, reg_read}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_addr", {24'd0, reg_addr}, 32'd0);
        check("rst_wdata", {24'd0, reg_wdata}, 32'd0);
        rstn = 1'b1;
        wait_q();

        // Pointer write then two data bytes
        i2c_start();
        write_byte(8'hD0, ack); check("t1_addr_ack", {31'd0, ack}, 32'd0);
        write_byte(8'h05, ack); check("t1_ptr_ack", {31'd0, ack}, 32'd0);
        write_byte(8'hA5, ack); check("t1_d0_ack", {31'd0, ack}, 32'd0);
        write_byte(8'h3C, ack); check("t1_d1_ack", {31'd0, ack}, 32'd0);
        i2c_stop(); wait_q();
        check("t1_wr_cnt", wr_cnt, 2);
        check("t1_wr_addr0", {24'd0, wr_addr[0]}, 32'h05);
        check("t1_wr_data0", {24'd0, wr_data[0]}, 32'hA5);
        check("t1_wr_addr1", {24'd0, wr_addr[1]}, 32'h06);
        check("t1_wr_data1", {24'd0, wr_data[1]}, 32'h3C);
        check("t1_busy_after_stop", {31'd0, busy}, 32'd0);
        check("t1_oe_after_stop", {31'd0, i2c_sda_oe}, 32'd0);

        // Current-pointer read shows the pointer landed on 7
        i2c_start();
        write_byte(8'hD1, ack); check("t1r_addr_ack", {31'd0, ack}, 32'd0);
        read_byte(rbyte, 1'b0);
        i2c_stop(); wait_q();
        check("t1r_rd_cnt", rd_cnt, 1);
        check("t1r_rd_addr", {24'd0, rd_addr[0]}, 32'h07);
        check("t1r_byte", {24'd0, rbyte}, 32'h77);

        // Foreign address is ignored
        oe_seen = 1'b0; busy_seen = 1'b0;
        i2c_start();
        write_byte(8'hA0, ack); check("t2_nack", {31'd0, ack}, 32'd1);
        i2c_stop(); wait_q();
        check("t2_oe_seen", {31'd0, oe_seen}, 32'd0);
        check("t2_busy_seen", {31'd0, busy_seen}, 32'd0);
        check("t2_wr_cnt", wr_cnt, 2);
        check("t2_rd_cnt", rd_cnt, 1);

        // Pointer 0x3F, repeated START, sequential read wrapping to 0
        i2c_start();
        write_byte(8'hD0, ack); check("t3_addr_ack", {31'd0, ack}, 32'd0);
        write_byte(8'h3F, ack); check("t3_ptr_ack", {31'd0, ack}, 32'd0);
        i2c_rstart();
        write_byte(8'hD1, ack); check("t3_raddr_ack", {31'd0, ack}, 32'd0);
        read_byte(rbyte, 1'b1); check("t3_byte0", {24'd0, rbyte}, 32'h11);
        read_byte(rbyte, 1'b0); check("t3_byte1", {24'd0, rbyte}, 32'h22);
        check("t3_busy_after_nack", {31'd0, busy}, 32'd0);
        i2c_stop(); wait_q();
        check("t3_rd_cnt", rd_cnt, 3);
        check("t3_rd_addr0", {24'd0, rd_addr[1]}, 32'h3F);
        check("t3_rd_addr1", {24'd0, rd_addr[2]}, 32'h00);

        // STOP after four data bits aborts the byte
        i2c_start();
        write_byte(8'hD0, ack); check("t4_addr_ack", {31'd0, ack}, 32'd0);
        write_byte(8'h10, ack); check("t4_ptr_ack", {31'd0, ack}, 32'd0);
        for (int i = 0; i < 4; i++) write_bit(1'b1);
        i2c_stop(); wait_q();
        check("t4_no_write", wr_cnt, 2);
        check("t4_oe", {31'd0, i2c_sda_oe}, 32'd0);
        check("t4_busy", {31'd0, busy}, 32'd0);
        i2c_start();
        write_byte(8'hD0, ack); check("t4b_addr_ack", {31'd0, ack}, 32'd0);
        write_byte(8'h20, ack); check("t4b_ptr_ack", {31'd0, ack}, 32'd0);
        write_byte(8'h5A, ack); check("t4b_d_ack", {31'd0, ack}, 32'd0);
        i2c_stop(); wait_q();
        check("t4b_wr_cnt", wr_cnt, 3);
        check("t4b_wr_addr", {24'd0, wr_addr[2]}, 32'h20);
        check("t4b_wr_data", {24'd0, wr_data[2]}, 32'h5A);

        // Reset pulse while the target drives an ACK
        i2c_start();
        write_byte(8'hD0, ack);
        write_byte(8'h12, ack);
        i2c_stop(); wait_q();
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(i == 0 ? 1'b1 : (8'hD1 >> i) & 1'b1 ? 1'b1 : 1'b0);
        sda_m = 1'b1; wait_q();
        scl = 1'b1; wait_q();
        check("t5_oe_in_ack", {31'd0, i2c_sda_oe}, 32'd1);
        rstn = 1'b0;
        #1;
        check("t5_oe_async", {31'd0, i2c_sda_oe}, 32'd0);
        wait_q();
        rstn = 1'b1;
        scl = 1'b0; wait_q();
        i2c_stop(); wait_q();
        i2c_start();
        write_byte(8'hD1, ack); check("t5_addr_ack", {31'd0, ack}, 32'd0);
        read_byte(rbyte, 1'b0);
        i2c_stop(); wait_q();
        check("t5_rd_addr", {24'd0, rd_addr[rd_cnt-1]}, 32'h00);
        check("t5_byte", {24'd0, rbyte}, 32'h22);

        // 2-cycle high glitch on SDA while SCL high (SDA low beforehand)
        scl = 1'b0; wait_q();
        sda_m = 1'b0; wait_q();
        scl = 1'b1; wait_q();
        sda_m = 1'b1;
        repeat (2) @(negedge sys_clk);
        sda_m = 1'b0; wait_q();
        scl = 1'b0; wait_q();
        write_byte(8'hD0, ack);
`ifdef I2C_TGT_GLITCH_FILTER_EN
        check("t6_glitch_ack", {31'd0, ack}, 32'd1);
        check("t6_glitch_busy", {31'd0, busy}, 32'd0);
`else
        check("t6_glitch_ack", {31'd0, ack}, 32'd0);
        check("t6_glitch_busy", {31'd0, busy}, 32'd1);
`endif
        i2c_stop(); wait_q();
        check("t6_busy_after_stop", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
